// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO: FWFT or registered-read mode, programmable thresholds, occupancy.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags and err_clear logic.
module fifo_prog #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int FWFT  = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             alFull,
  output logic             alEmpty,
  output logic [CW-1:0]    count,
  input  logic [CW-1:0]    al_full_thresh,
  input  logic [CW-1:0]    al_empty_thresh,
  input  logic             err_clear,
  output logic             overflow,
  output logic             underflow
);
  localparam int            PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_s, rd_s;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == {CW{1'b0}});
  assign alFull  = (count_q >= al_full_thresh);
  assign alEmpty = (count_q <= al_empty_thresh);
  assign count   = count_q;

  // A pop paired with a dropped push is held off too, so a full FIFO is left completely untouched.
  assign wr_s = push && !full;
  assign rd_s = pop && !empty && !(push && full);

  // Next-state pointers (explicit wrap for non-power-of-two depths) and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are invalidated by the pointer reset, so no reset here
  always_ff @(posedge clock) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign valid    = !empty;
    assign data_out = valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Registered read: one-cycle valid pulse per accepted read, data held otherwise
    always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
        dout_q  <= {WIDTH{1'b0}};
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_s;
        if (rd_s) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign data_out = dout_q;
    assign valid    = valid_q;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; a new error in the clearing cycle takes priority
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (push && full) ? 1'b1 : (err_clear ? 1'b0 : overflow_q);
      underflow_q <= (pop && empty) ? 1'b1 : (err_clear ? 1'b0 : underflow_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clear_s;
  assign unused_err_clear_s = err_clear;
  assign overflow           = 1'b0;
  assign underflow          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Self-checking bench for fifo_prog: DEPTH 32 FWFT, DEPTH 5 FWFT (thresholds, wrap), DEPTH 4 standard read.
module tb_fifo_prog;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: DEPTH 32, FWFT
  logic        a_push, a_pop, a_clr;
  logic [31:0] a_din, a_dout;
  logic        a_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [5:0]  a_cnt, a_aft, a_aet;

  // Instance C: DEPTH 5, FWFT
  logic        c_push, c_pop, c_clr;
  logic [7:0]  c_din, c_dout;
  logic        c_valid, c_full, c_empty, c_afull, c_aempty, c_ovf, c_unf;
  logic [2:0]  c_cnt, c_aft, c_aet;

  // Instance B: DEPTH 4, standard read
  logic        b_push, b_pop, b_clr;
  logic [7:0]  b_din, b_dout;
  logic        b_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [2:0]  b_cnt, b_aft, b_aet;

  fifo_prog #(.WIDTH(32), .DEPTH(32), .FWFT(1)) u_a (
    .clock(clk), .rstn(rstn), .push(a_push), .data_in(a_din), .pop(a_pop),
    .data_out(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
    .alFull(a_afull), .alEmpty(a_aempty), .count(a_cnt),
    .al_full_thresh(a_aft), .al_empty_thresh(a_aet), .err_clear(a_clr),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_prog #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_c (
    .clock(clk), .rstn(rstn), .push(c_push), .data_in(c_din), .pop(c_pop),
    .data_out(c_dout), .valid(c_valid), .full(c_full), .empty(c_empty),
    .alFull(c_afull), .alEmpty(c_aempty), .count(c_cnt),
    .al_full_thresh(c_aft), .al_empty_thresh(c_aet), .err_clear(c_clr),
    .overflow(c_ovf), .underflow(c_unf));

  fifo_prog #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_b (
    .clock(clk), .rstn(rstn), .push(b_push), .data_in(b_din), .pop(b_pop),
    .data_out(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
    .alFull(b_afull), .alEmpty(b_aempty), .count(b_cnt),
    .al_full_thresh(b_aft), .al_empty_thresh(b_aet), .err_clear(b_clr),
    .overflow(b_ovf), .underflow(b_unf));

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [2:0] aft;
    logic [2:0] aet;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] qa[$];
  logic [7:0]  qc[$];
  logic [7:0]  qb[$];
  logic [7:0]  qexp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model step for C: decides acceptance from the queue, then clocks the DUT
  task automatic c_step(input logic p, input logic q, input logic [7:0] d);
    logic wr_m, rd_m;
    c_push = p; c_pop = q; c_din = d;
    wr_m = p && (qc.size() < 5);
    rd_m = q && (qc.size() > 0) && !(p && qc.size() == 5);
    if (rd_m) void'(qc.pop_front());
    if (wr_m) qc.push_back(d);
    tick;
    c_push = 1'b0; c_pop = 1'b0;
  endtask

  // Model step for B: accepted reads push their expected word to qexp, checked on valid
  task automatic b_step(input logic p, input logic q, input logic clr, input logic [7:0] d);
    logic wr_m, rd_m;
    b_push = p; b_pop = q; b_clr = clr; b_din = d;
    wr_m = p && (qb.size() < 4);
    rd_m = q && (qb.size() > 0) && !(p && qb.size() == 4);
    if (rd_m) qexp.push_back(qb.pop_front());
    if (wr_m) qb.push_back(d);
    tick;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0;
    check("b_valid", b_valid, rd_m);
    if (rd_m && qexp.size() > 0) check("b_data", b_dout, qexp.pop_front());
    check("b_count", b_cnt, qb.size());
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h01, 3'd4, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'h02, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h03, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h04, 3'd5, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 8'h05, 3'd4, 3'd7, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'h06, 3'd5, 3'd2, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h07, 3'd5, 3'd4, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 3'd3, 3'd3, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};

    rstn = 1'b0;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = 32'h0; a_aft = 6'd28; a_aet = 6'd2;
    c_push = 1'b0; c_pop = 1'b0; c_clr = 1'b0; c_din = 8'h0; c_aft = 3'd4; c_aet = 3'd1;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = 8'h0; b_aft = 3'd3; b_aet = 3'd1;
    #12;
    rstn = 1'b1;

    check("rst_empty", a_empty, 1'b1);
    check("rst_alempty", a_aempty, 1'b1);
    check("rst_count", a_cnt, 6'd0);
    check("rst_full", a_full, 1'b0);
    check("rst_valid", a_valid, 1'b0);
    check("rst_alfull", a_afull, 1'b0);
    check("rst_dout", a_dout, 32'h0);
    check("rst_ovf", a_ovf, 1'b0);
    check("rst_unf", a_unf, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_b_dout", b_dout, 8'h0);

    for (int i = 0; i < 32; i++) begin
      a_push = 1'b1; a_din = 32'(i);
      qa.push_back(32'(i));
      tick;
      check($sformatf("fill%0d_count", i), a_cnt, 64'(i + 1));
      check($sformatf("fill%0d_alfull", i), a_afull, (i + 1) >= 28);
      check($sformatf("fill%0d_full", i), a_full, (i + 1) == 32);
    end
    a_din = 32'h99; a_pop = 1'b1;
    tick;
    a_push = 1'b0; a_pop = 1'b0;
    check("ovf_count", a_cnt, 6'd32);
    check("ovf_full", a_full, 1'b1);
    check("ovf_flag", a_ovf, ERR_EN);

    a_pop = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain%0d_valid", i), a_valid, 1'b1);
      check($sformatf("drain%0d_data", i), a_dout, qa.pop_front());
      tick;
    end
    check("drain_empty", a_empty, 1'b1);
    check("drain_valid", a_valid, 1'b0);
    tick;
    a_pop = 1'b0;
    check("unf_flag", a_unf, ERR_EN);
    check("unf_count", a_cnt, 6'd0);

    for (int i = 0; i < 8; i++) begin
      c_aft = tbl[i].aft; c_aet = tbl[i].aet;
      c_step(tbl[i].push, tbl[i].pop, tbl[i].din);
      check($sformatf("tbl%0d_count", i), c_cnt, tbl[i].cnt);
      check($sformatf("tbl%0d_full", i), c_full, tbl[i].full);
      check($sformatf("tbl%0d_empty", i), c_empty, tbl[i].empty);
      check($sformatf("tbl%0d_alfull", i), c_afull, tbl[i].afull);
      check($sformatf("tbl%0d_alempty", i), c_aempty, tbl[i].aempty);
      if (qc.size() > 0) check($sformatf("tbl%0d_data", i), c_dout, qc[0]);
    end

    c_aft = 3'd4; c_aet = 3'd1;
    for (int i = 0; i < 100; i++) begin
      c_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      check("wrap_count", c_cnt, qc.size());
      check("wrap_bound", c_cnt <= 3'd5, 1'b1);
      check("wrap_valid", c_valid, qc.size() != 0);
      check("wrap_alfull", c_afull, qc.size() >= 4);
      check("wrap_alempty", c_aempty, qc.size() <= 1);
      if (qc.size() > 0) check("wrap_data", c_dout, qc[0]);
    end

    b_step(1'b1, 1'b0, 1'b0, 8'hA5);
    b_step(1'b0, 1'b1, 1'b0, 8'h00);
    b_step(1'b0, 1'b0, 1'b0, 8'h00);
    check("std_hold", b_dout, 8'hA5);
    b_step(1'b0, 1'b1, 1'b0, 8'h00);
    check("std_unf", b_unf, ERR_EN);
    b_step(1'b0, 1'b0, 1'b1, 8'h00);
    check("std_unf_clr", b_unf, 1'b0);
    for (int i = 1; i <= 4; i++) b_step(1'b1, 1'b0, 1'b0, 8'(i));
    b_step(1'b1, 1'b0, 1'b0, 8'h55);
    check("err_ovf", b_ovf, ERR_EN);
    check("err_full", b_full, 1'b1);
    b_step(1'b1, 1'b0, 1'b1, 8'h66);
    check("err_set_wins", b_ovf, ERR_EN);
    b_step(1'b0, 1'b0, 1'b1, 8'h00);
    check("err_clear", b_ovf, 1'b0);
    for (int i = 0; i < 4; i++) b_step(1'b0, 1'b1, 1'b0, 8'h00);
    b_step(1'b0, 1'b0, 1'b0, 8'h00);
    check("std_end_empty", b_empty, 1'b1);

    c_step(1'b1, 1'b0, 8'h11);
    c_step(1'b1, 1'b0, 8'h22);
    #2;
    rstn = 1'b0;
    #1;
    check("async_count", c_cnt, 3'd0);
    check("async_empty", c_empty, 1'b1);
    check("async_valid", c_valid, 1'b0);
    #3;
    rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO, successor to the single-mode AFU FIFO. It adds several features:
- a compile-time read mode, either first-word-fall-through (FWFT) or standard registered-read;
- runtime-programmable almost-full and almost-empty thresholds;
- an occupancy output;
- non-power-of-two depth support;
- optional sticky overflow/underflow error flags.

It sits between CAPI command/response paths and AFU engines wherever rate decoupling with flow-control headroom is needed.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 32, number of entries (>=2, any integer, not restricted to a power of two)
- FWFT, 1, read mode: 1 = first-word-fall-through, 0 = standard registered read
- CW, $clog2(DEPTH+1), width of count and threshold ports

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- push  in  1  write request
- data_in  in  WIDTH  write data, sampled when push && !full
- pop  in  1  read request (FWFT: acknowledge of data_out; standard: request next word)
- data_out  out  WIDTH  read data, meaningful only while valid
- valid  out  1  data_out holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- alFull  out  1  count >= al_full_thresh
- alEmpty  out  1  count <= al_empty_thresh
- count  out  CW  number of stored words, 0..DEPTH
- al_full_thresh  in  CW  programmable almost-full level
- al_empty_thresh  in  CW  programmable almost-empty level
- err_clear  in  1  clears overflow/underflow
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted with nothing to read

## Operation
- Accepted write: wr = push && !full. Accepted read: rd = pop && !empty.
- Pointer and count behaviour:
  - wr stores data_in at wr_ptr.
  - rd advances rd_ptr.
  - Both pointers wrap from DEPTH-1 to 0 (explicit compare, not bit overflow).
  - count: +1 on wr only, -1 on rd only, unchanged on both or neither.
- Boundary cases:
  - Push while full is dropped; the stored data and count are untouched, even if pop is asserted in the same cycle (no full-bypass).
  - Pop while empty is ignored, even if push is asserted in the same cycle (no empty-bypass).
- Status flags:
  - full, empty, alFull and alEmpty are combinational from the registered count and the threshold ports.
  - Threshold changes take effect in the same cycle.
  - al_full_thresh = 0 forces alFull = 1. al_empty_thresh >= DEPTH forces alEmpty = 1.
- FWFT = 1:
  - valid = !empty, and data_out = mem[rd_ptr] whenever valid.
  - pop && valid consumes the word; the next word (if any) is presented the following cycle.
- FWFT = 0:
  - rd in cycle t registers mem[rd_ptr] to data_out, and valid = 1 in cycle t+1 only (one-cycle pulse per read).
  - data_out holds its last value when valid = 0.
- Error flags:
  - overflow sets on push && full; underflow sets on pop && empty.
  - Both clear on err_clear; a set in the same cycle as err_clear wins.

## Timing
- Reset values: count = 0, empty = 1, full = 0, valid = 0, data_out = 0, overflow = 0, underflow = 0, pointers = 0.
  - alFull and alEmpty follow their combinational definitions from count = 0 and the thresholds (alFull = 1 only if al_full_thresh = 0; alEmpty = 1).
  - Reset mid-operation discards all contents immediately (asynchronous).
- Write-to-status latency: a wr in cycle t updates count, empty and full at t+1.
- FWFT write-to-read latency: the word written at t appears on data_out with valid = 1 at t+1.
- Standard-mode read latency: one cycle from rd to valid.
- Throughput: one push and one pop per cycle sustained, with count steady.
- Error flags assert one cycle after the offending request.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow/underflow sticky registers and err_clear logic are built as described.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0, err_clear is ignored, and no error registers are synthesised.

## Test plan
- Reset with al_full_thresh = 28, al_empty_thresh = 2, DEPTH = 32, FWFT = 1: initial flags -> empty = 1, alEmpty = 1, count = 0, full = 0, valid = 0, alFull = 0.
- Fill: 32 pushes of values 0..31 -> alFull rises after the 28th push, full = 1 and count = 32 after the 32nd; a 33rd push with pop = 1 -> data dropped, count stays 32, overflow = 1 next cycle.
- FWFT drain: pop held for 32 cycles -> data_out 0..31 in order, one per cycle; empty = 1 after the last, then one extra pop -> underflow = 1.
- Wrap, DEPTH = 5: 100 cycles of random simultaneous push/pop -> order preserved across pointer wraps 4->0, count never exceeds 5.
- FWFT = 0: push 0xA5, then pop at cycle t -> valid = 1 and data_out = 0xA5 at t+1 only; pop on an empty FIFO -> valid stays 0.
- Errors: overflow set and err_clear asserted together with a new push while full -> overflow remains 1; err_clear alone -> overflow = 0 next cycle. With FIFO_ERR_FLAGS_EN undefined, overflow and underflow stay 0 throughout.
